// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and limits for the truth-table sweeper: FSM state encoding,
// parameter ceilings and the settle-timer load helper.
package truth_table_sweeper_pkg;

    localparam int unsigned MAX_N_IN       = 8;
    localparam int unsigned MAX_SETTLE_CYC = 15;
    localparam int unsigned SETTLE_W       = $clog2(MAX_SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    // The timer counts down to zero inclusive, so it is loaded with one less
    // than the number of settle cycles wanted.
    function automatic logic [SETTLE_W-1:0] settle_load(input int unsigned cyc);
        return SETTLE_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status and function-under-test signals of the sweeper, grouped so
// the controlling side (master) and the sweeper (slave) share one bundle.
interface truth_table_sweeper_if #(
    parameter int unsigned N_IN = 3
);
    logic                   start;
    logic [2**N_IN-1:0]     expected;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          fail_count;
    logic                   first_fail_valid;
    logic [N_IN-1:0]        first_fail_vec;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter; tc pulses for one cycle once the loaded count has
// run down to zero, then stays low until the next load.
module settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned W = SETTLE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic         armed_q;

    assign tc = armed_q && (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            armed_q <= 1'b1;
        end else if (tc) begin
            armed_q <= 1'b0;
        end else if (armed_q) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustively drives every input vector of an N_IN-input combinational
// function, compares its response with a latched golden truth table and
// reports fail count, first failing vector and pass/done status.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned N_IN         = 3,
    parameter int unsigned SETTLE_CYC   = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);

    localparam int unsigned N_VEC = 2**N_IN;

    sweep_state_e        state_q, state_d;
    logic [N_VEC-1:0]    exp_q;
    logic [N_IN-1:0]     vec_q;
    logic [N_IN:0]       fail_q;
    logic                ffv_q;
    logic [N_IN-1:0]     ffvec_q;

    logic                accept;
    logic                check_en;
    logic                advance;
    logic                timer_load;
    logic                timer_tc;
    logic                mismatch;
    logic                last_vec;

    assign mismatch = (bus.dut_out != exp_q[vec_q]);
    assign last_vec = &vec_q;

    settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (settle_load(SETTLE_CYC)),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        check_en   = 1'b0;
        advance    = 1'b0;
        timer_load = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.pass   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                bus.done = (state_q == DONE);
                bus.pass = (state_q == DONE) && (fail_q == '0);
                if (bus.start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                bus.busy = 1'b1;
                if (timer_tc) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                bus.busy = 1'b1;
                check_en = 1'b1;
                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    state_d = DONE;
                end else begin
                    advance    = 1'b1;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The golden table is captured at start so later changes on expected
    // cannot disturb a sweep already in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q   <= '0;
            vec_q   <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else if (accept) begin
            exp_q  <= bus.expected;
            vec_q  <= '0;
            fail_q <= '0;
            ffv_q  <= 1'b0;
        end else if (check_en) begin
            if (mismatch) begin
                fail_q <= fail_q + 1'b1;
                if (!ffv_q) begin
                    ffv_q   <= 1'b1;
                    ffvec_q <= vec_q;
                end
            end
            if (advance) begin
                vec_q <= vec_q + 1'b1;
            end
        end
    end

    assign bus.dut_in           = vec_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 3: number of inputs of the combinational function under test (1..8).
REQ-002 Parameter SETTLE_CYC, default 1: wait cycles between applying a vector and sampling the result (1..15).
REQ-003 Parameter STOP_ON_FAIL, default 0: 1 ends the sweep at the first mismatch; 0 sweeps all vectors.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 expected  input  2**N_IN  golden truth table; bit k is the expected output for input vector k.
REQ-008 dut_in  output  N_IN  registered vector driven to the function under test; MSB is the first input (A of {A,B,C}).
REQ-009 dut_out  input  1  response of the function under test.
REQ-010 busy  output  1  high from the cycle after an accepted start until the sweep ends.
REQ-011 done  output  1  high from sweep end until the next accepted start or reset.
REQ-012 pass  output  1  done AND fail_count==0.
REQ-013 fail_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
REQ-014 first_fail_valid  output  1  high once any mismatch has been recorded in the current or last sweep.
REQ-015 first_fail_vec  output  N_IN  vector of the first mismatch; meaningful only when first_fail_valid=1.

Function
REQ-016 FSM states IDLE, SETTLE, CHECK, DONE; the DONE state asserts done.
REQ-017 start is accepted only in IDLE or DONE; it is ignored in SETTLE and CHECK.
REQ-018 On an accepted start: latch expected, set dut_in=0, settle counter=0, fail_count=0, clear first_fail_valid, clear done, enter SETTLE.
REQ-019 SETTLE holds dut_in for SETTLE_CYC cycles, then enters CHECK.
REQ-020 CHECK lasts one cycle and compares dut_out with latched expected[dut_in].
REQ-021 On a mismatch: increment fail_count; if first_fail_valid=0, load first_fail_vec=dut_in and set first_fail_valid.
REQ-022 CHECK exit: go to DONE if dut_in==2**N_IN-1, or if STOP_ON_FAIL=1 and a mismatch occurred; otherwise increment dut_in and return to SETTLE.
REQ-023 Each vector takes SETTLE_CYC+1 cycles; a full sweep sets done exactly 2**N_IN*(SETTLE_CYC+1) cycles after the start cycle.
REQ-024 dut_in does not wrap; the last vector exits to DONE, and fail_count is sized so that 2**N_IN fails never overflow.
REQ-025 Changes on expected after start do not affect the running sweep.
REQ-026 In DONE, dut_in, fail_count and the first_fail outputs hold their values; a start in DONE restarts per REQ-018.

Reset
REQ-027 Reset wins over start in the same cycle.
REQ-028 Reset mid-sweep abandons the sweep within one cycle.
REQ-029 Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_vec=0.

Structure
REQ-030 A shared package holds the FSM state typedef and the maximum limits for N_IN and SETTLE_CYC.
REQ-031 One sub-module, settle_timer, is a loadable down-counter that produces a terminal-count pulse after SETTLE_CYC cycles.

Verification
REQ-032 Correct model, N_IN=3, SETTLE_CYC=1, expected=8'b1110_0100, start pulse: done rises 16 cycles after start; pass=1, fail_count=0, first_fail_valid=0.
REQ-033 Same setup, but the model outputs 1 at A=0,B=0,C=1 (expected 0): fail_count=1, first_fail_vec=3'b001, pass=0.
REQ-034 STOP_ON_FAIL=1, model wrong at vectors 2 and 5: done at CHECK of vector 2; fail_count=1, first_fail_vec=3'b010, dut_in holds 3'b010.
REQ-035 Reset asserted at cycle 6 of a sweep: next cycle shows all reset values; a later start completes a normal full sweep.
REQ-036 Start re-pulsed while busy, and expected changed mid-sweep: both are ignored and the results match REQ-032.
REQ-037 N_IN=4, SETTLE_CYC=3, model always outputs 0, expected=16'hFFFF: fail_count=16, first_fail_vec=0, done 64 cycles after start.
